spi_rx_module: RTL and testbench

SPI receive shifter, companion to the SPI transmit shifter on the same link. It samples MISO on one-cycle SCK edge strobes from the shared SPI clock generator and assembles a DATA_W-bit word. The word goes to a holding register with a Valid/Rd_Ack handshake and a sticky overrun flag. It sits beside the transmitter in the SPI master datapath; both are started by the same En strobe and driven by the same H2L_Sig/L2H_Sig edge strobes.

---
 rtl/spi_rx_module.sv | 115 +++++++++++
 tb/tb_spi_rx_module.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_module.sv
// SPI receive shifter: samples MISO on the selected SCK edge strobe, assembles a
// DATA_W-bit word and hands it off through a Valid/Rd_Ack holding register.
module spi_rx_module #(
    parameter logic SAMPLE_EDGE = 1'b0,
    parameter int   DATA_W      = 8,
    parameter logic LSB_FIRST   = 1'b0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              MISO,
    input  logic              En,
    input  logic              H2L_Sig,
    input  logic              L2H_Sig,
    input  logic              Rd_Ack,
    output logic              Busy_Sig,
    output logic              Done_Sig,
    output logic              Valid_Sig,
    output logic              Ovr_Sig,
    output logic [DATA_W-1:0] Data
);

    localparam int               CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              samp;
    logic              last_samp;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] sr_nxt;
    logic              ovr_pend;

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur,
                                                   input logic              bit_in);
        if (LSB_FIRST)
            return {bit_in, cur[DATA_W-1:1]};
        else
            return {cur[DATA_W-2:0], bit_in};
    endfunction

    assign samp      = SAMPLE_EDGE ? H2L_Sig : L2H_Sig;
    assign last_samp = (state == RECV) && samp && (cnt == LAST_CNT);
    assign sr_nxt    = shift_in(sr, MISO);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (En) state_nxt = RECV;
            RECV:    if (last_samp) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The word, Done and Valid are loaded on the final sample so they are all
    // visible during the DONE cycle; the overrun decision waits until the end of
    // that cycle so an Rd_Ack arriving alongside Done_Sig can still claim the old word.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            Busy_Sig  <= 1'b0;
            Done_Sig  <= 1'b0;
            Valid_Sig <= 1'b0;
            Ovr_Sig   <= 1'b0;
            Data      <= '0;
            sr        <= '0;
            cnt       <= '0;
            ovr_pend  <= 1'b0;
        end else begin
            Done_Sig <= 1'b0;
            if (Rd_Ack && state != DONE) begin
                Valid_Sig <= 1'b0;
                Ovr_Sig   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (En) begin
                        Busy_Sig <= 1'b1;
                        cnt      <= '0;
                        sr       <= '0;
                    end
                end
                RECV: begin
                    if (samp) begin
                        sr  <= sr_nxt;
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (last_samp) begin
                        Data      <= sr_nxt;
                        Done_Sig  <= 1'b1;
                        Busy_Sig  <= 1'b0;
                        Valid_Sig <= 1'b1;
                        ovr_pend  <= Valid_Sig && !Rd_Ack;
                    end
                end
                DONE: begin
                    if (ovr_pend && !Rd_Ack)
                        Ovr_Sig <= 1'b1;
                    ovr_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rx_module.sv
// Directed bench for spi_rx_module: four instances cover MSB/LSB order,
// falling-edge sampling and a 16-bit frame; each has its own En line.
module tb_spi_rx_module;

    logic        CLK    = 1'b0;
    logic        RSTn   = 1'b0;
    logic        MISO   = 1'b0;
    logic        H2L    = 1'b0;
    logic        L2H    = 1'b0;
    logic        Rd_Ack = 1'b0;
    logic [3:0]  en     = '0;
    logic [3:0]  busy, done, valid, ovr;
    logic [7:0]  d0, d1, d2;
    logic [15:0] d3;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          dcnt [4];
    int          c0;

    always #5 CLK = ~CLK;

    spi_rx_module #(.SAMPLE_EDGE(1'b0), .DATA_W(8), .LSB_FIRST(1'b0)) u0 (
        .CLK(CLK), .RSTn(RSTn), .MISO(MISO), .En(en[0]), .H2L_Sig(H2L), .L2H_Sig(L2H),
        .Rd_Ack(Rd_Ack), .Busy_Sig(busy[0]), .Done_Sig(done[0]), .Valid_Sig(valid[0]),
        .Ovr_Sig(ovr[0]), .Data(d0));
    spi_rx_module #(.SAMPLE_EDGE(1'b0), .DATA_W(8), .LSB_FIRST(1'b1)) u1 (
        .CLK(CLK), .RSTn(RSTn), .MISO(MISO), .En(en[1]), .H2L_Sig(H2L), .L2H_Sig(L2H),
        .Rd_Ack(Rd_Ack), .Busy_Sig(busy[1]), .Done_Sig(done[1]), .Valid_Sig(valid[1]),
        .Ovr_Sig(ovr[1]), .Data(d1));
    spi_rx_module #(.SAMPLE_EDGE(1'b1), .DATA_W(8), .LSB_FIRST(1'b0)) u2 (
        .CLK(CLK), .RSTn(RSTn), .MISO(MISO), .En(en[2]), .H2L_Sig(H2L), .L2H_Sig(L2H),
        .Rd_Ack(Rd_Ack), .Busy_Sig(busy[2]), .Done_Sig(done[2]), .Valid_Sig(valid[2]),
        .Ovr_Sig(ovr[2]), .Data(d2));
    spi_rx_module #(.SAMPLE_EDGE(1'b0), .DATA_W(16), .LSB_FIRST(1'b0)) u3 (
        .CLK(CLK), .RSTn(RSTn), .MISO(MISO), .En(en[3]), .H2L_Sig(H2L), .L2H_Sig(L2H),
        .Rd_Ack(Rd_Ack), .Busy_Sig(busy[3]), .Done_Sig(done[3]), .Valid_Sig(valid[3]),
        .Ovr_Sig(ovr[3]), .Data(d3));

    always @(posedge CLK)
        for (int k = 0; k < 4; k++)
            if (done[k]) dcnt[k]++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // bits is the serial sequence, first bit in bits[n-1]; en_at re-pulses En mid-frame.
    task automatic frame(input int idx, input logic [31:0] bits, input int n, input int gap,
                         input bit h2l, input bit noise, input int en_at);
        en[idx] = 1'b1;
        tick();
        en[idx] = 1'b0;
        check("busy_rise", {31'd0, busy[idx]}, 32'd1);
        for (int i = 0; i < n; i++) begin
            for (int g = 1; g < gap; g++) begin
                if (noise) begin
                    if (h2l) L2H = 1'b1;
                    else     H2L = 1'b1;
                end
                if (i == en_at && g == 1) en[idx] = 1'b1;
                tick();
                L2H = 1'b0;
                H2L = 1'b0;
                en[idx] = 1'b0;
            end
            MISO = bits[n-1-i];
            if (h2l) H2L = 1'b1;
            else     L2H = 1'b1;
            tick();
            H2L = 1'b0;
            L2H = 1'b0;
        end
    endtask

    // Called in the cycle right after the last strobe.
    task automatic post(input int idx, input logic [31:0] exp, input bit ack_done);
        logic [31:0] dv;
        case (idx)
            0:       dv = {24'd0, d0};
            1:       dv = {24'd0, d1};
            2:       dv = {24'd0, d2};
            default: dv = {16'd0, d3};
        endcase
        check("done_pulse", {31'd0, done[idx]}, 32'd1);
        check("busy_fall", {31'd0, busy[idx]}, 32'd0);
        check("valid_set", {31'd0, valid[idx]}, 32'd1);
        check("data", dv, exp);
        if (ack_done) Rd_Ack = 1'b1;
        tick();
        Rd_Ack = 1'b0;
        check("done_one_cycle", {31'd0, done[idx]}, 32'd0);
    endtask

    task automatic ack();
        Rd_Ack = 1'b1;
        tick();
        Rd_Ack = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        check("rst_busy", {28'd0, busy}, 32'd0);
        check("rst_done", {28'd0, done}, 32'd0);
        check("rst_valid", {28'd0, valid}, 32'd0);
        check("rst_ovr", {28'd0, ovr}, 32'd0);
        check("rst_data0", {24'd0, d0}, 32'd0);
        check("rst_data3", {16'd0, d3}, 32'd0);
        RSTn = 1'b1;
        tick();

        // Mode 0 MSB first, strobes 4 cycles apart
        frame(0, 32'hA5, 8, 4, 1'b0, 1'b0, -1);
        post(0, 32'hA5, 1'b0);
        ack();
        check("ack_clears_valid", {31'd0, valid[0]}, 32'd0);

        frame(1, 32'hC5, 8, 2, 1'b0, 1'b0, -1);
        post(1, 32'hA3, 1'b0);

        frame(2, 32'hC5, 8, 3, 1'b1, 1'b1, -1);
        post(2, 32'hC5, 1'b0);

        // Overrun without ack
        frame(0, 32'h12, 8, 2, 1'b0, 1'b0, -1);
        post(0, 32'h12, 1'b0);
        check("no_ovr_first", {31'd0, ovr[0]}, 32'd0);
        frame(0, 32'h34, 8, 2, 1'b0, 1'b0, -1);
        post(0, 32'h34, 1'b0);
        check("ovr_set", {31'd0, ovr[0]}, 32'd1);
        check("ovr_valid", {31'd0, valid[0]}, 32'd1);
        ack();
        check("ovr_ack_valid", {31'd0, valid[0]}, 32'd0);
        check("ovr_ack_ovr", {31'd0, ovr[0]}, 32'd0);

        // Ack in the DONE cycle claims the old word
        frame(0, 32'h12, 8, 2, 1'b0, 1'b0, -1);
        post(0, 32'h12, 1'b0);
        frame(0, 32'h34, 8, 2, 1'b0, 1'b0, -1);
        post(0, 32'h34, 1'b1);
        tick();
        check("ackdone_ovr", {31'd0, ovr[0]}, 32'd0);
        check("ackdone_valid", {31'd0, valid[0]}, 32'd1);
        check("ackdone_data", {24'd0, d0}, 32'h34);
        ack();

        // En pulse after 3 strobes is ignored
        frame(0, 32'h3C, 8, 3, 1'b0, 1'b0, 3);
        post(0, 32'h3C, 1'b0);
        tick();
        check("en_ignored_idle", {31'd0, busy[0]}, 32'd0);

        // Reset after 4 strobes aborts the frame
        en[0] = 1'b1;
        tick();
        en[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            MISO = i[0];
            L2H = 1'b1;
            tick();
            L2H = 1'b0;
            tick();
        end
        RSTn = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy[0]}, 32'd0);
        check("arst_done", {31'd0, done[0]}, 32'd0);
        check("arst_valid", {31'd0, valid[0]}, 32'd0);
        check("arst_ovr", {31'd0, ovr[0]}, 32'd0);
        check("arst_data", {24'd0, d0}, 32'd0);
        tick();
        RSTn = 1'b1;
        tick();
        c0 = dcnt[0];
        frame(0, 32'h5A, 8, 2, 1'b0, 1'b0, -1);
        post(0, 32'h5A, 1'b0);
        check("post_rst_single_done", dcnt[0] - c0, 32'd1);

        // 16-bit frame with a strobe every cycle
        frame(3, 32'hBEEF, 16, 1, 1'b0, 1'b0, -1);
        post(3, 32'hBEEF, 1'b0);

        check("total_done_u0", dcnt[0], 32'd7);
        check("total_done_u3", dcnt[3], 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
